// File: rtl/ram_stream_reader_pkg.sv
// Shared constants and state encoding for the RAM-to-stream burst reader.
package ram_stream_reader_pkg;

    localparam int FIFO_DEPTH = 4;
    localparam int FIFO_PW    = $clog2(FIFO_DEPTH);
    localparam int FIFO_CW    = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // A new read may issue only if every outstanding word is guaranteed a FIFO slot.
    function automatic logic credit_ok(input logic [FIFO_CW-1:0] fifo_count,
                                       input logic [1:0]         in_flight);
        logic [FIFO_CW:0] sum;
        sum = (FIFO_CW + 1)'(fifo_count) + (FIFO_CW + 1)'(in_flight);
        return sum < (FIFO_CW + 1)'(FIFO_DEPTH);
    endfunction

endpackage

// File: rtl/ram_read_fifo.sv
// Small FIFO buffering RAM read data ahead of the output stream; head is shown
// directly on o_head.
module ram_read_fifo
    import ram_stream_reader_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rstN,
    input  logic               i_push,
    input  logic [WIDTH-1:0]   i_push_data,
    input  logic               i_pop,
    output logic [FIFO_CW-1:0] o_count,
    output logic               o_valid,
    output logic [WIDTH-1:0]   o_head
);

    logic [WIDTH-1:0]   r_mem [FIFO_DEPTH];
    logic [FIFO_PW-1:0] r_wr_ptr;
    logic [FIFO_PW-1:0] r_rd_ptr;
    logic [FIFO_CW-1:0] r_count;
    logic               w_push_ok;
    logic               w_pop_ok;

    assign w_pop_ok  = i_pop && (r_count != {FIFO_CW{1'b0}});
    assign w_push_ok = i_push && ((r_count != FIFO_CW'(FIFO_DEPTH)) || w_pop_ok);

    // Storage needs no reset: contents are only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_wr_ptr <= {FIFO_PW{1'b0}};
            r_rd_ptr <= {FIFO_PW{1'b0}};
            r_count  <= {FIFO_CW{1'b0}};
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + FIFO_PW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + FIFO_PW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + FIFO_CW'(1);
                2'b01:   r_count <= r_count - FIFO_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count = r_count;
    assign o_valid = (r_count != {FIFO_CW{1'b0}});
    assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/ram_stream_reader.sv
// Reads a burst of words from a single-port RAM with registered read data and
// presents them as a valid/ready stream, throttled by FIFO credit.
module ram_stream_reader
    import ram_stream_reader_pkg::*;
#(
    parameter  int WIDTH   = 8,
    parameter  int ENTRIES = 256,
    localparam int AW      = $clog2(ENTRIES),
    localparam int LW      = $clog2(ENTRIES + 1)
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             start,
    input  logic [AW-1:0]    startAddress,
    input  logic [LW-1:0]    length,
    output logic [AW-1:0]    ramAddress,
    input  logic [WIDTH-1:0] ramReadData,
    output logic [WIDTH-1:0] outData,
    output logic             outValid,
    input  logic             outReady,
    output logic             busy,
    output logic             done
);

    state_t             r_state;
    state_t             w_state_next;
    logic [AW-1:0]      r_addr;
    logic [LW-1:0]      r_remaining;
    logic [1:0]         r_in_flight;
    logic               r_ret_valid;
    logic               r_cap_valid;
    logic [WIDTH-1:0]   r_cap_data;
    logic               r_done;
    logic               r_busy;
    logic               w_done_next;
    logic               w_accept;
    logic               w_issue;
    logic               w_pop;
    logic               w_last_pop;
    logic [FIFO_CW-1:0] w_fifo_count;
    logic               w_fifo_valid;
    logic [WIDTH-1:0]   w_fifo_head;

    assign w_accept   = (r_state == IDLE) && start && (length != {LW{1'b0}});
    assign w_issue    = (r_state == READ) && credit_ok(w_fifo_count, r_in_flight);
    assign w_pop      = w_fifo_valid && outReady;
    // In-flight counts every issued word not yet pushed, so zero means nothing is behind the head.
    assign w_last_pop = w_pop && (w_fifo_count == FIFO_CW'(1)) && (r_in_flight == 2'd0);

    always_comb begin
        w_state_next = r_state;
        w_done_next  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (length != {LW{1'b0}}) begin
                        w_state_next = READ;
                    end else begin
                        w_done_next = 1'b1;
                    end
                end else begin
                    w_state_next = IDLE;
                end
            end
            READ: begin
                if (w_issue && (r_remaining == LW'(1))) begin
                    w_state_next = DRAIN;
                end else begin
                    w_state_next = READ;
                end
            end
            DRAIN: begin
                if (w_last_pop) begin
                    w_state_next = IDLE;
                    w_done_next  = 1'b1;
                end else begin
                    w_state_next = DRAIN;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_addr      <= {AW{1'b0}};
            r_remaining <= {LW{1'b0}};
        end else if (w_accept) begin
            r_addr      <= startAddress;
            r_remaining <= length;
        end else if (w_issue) begin
            r_addr      <= (r_addr == AW'(ENTRIES - 1)) ? {AW{1'b0}} : r_addr + AW'(1);
            r_remaining <= r_remaining - LW'(1);
        end
    end

    // RAM data is captured one cycle after it returns, so a word reaches the FIFO two edges after its issue.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_ret_valid <= 1'b0;
            r_cap_valid <= 1'b0;
            r_cap_data  <= {WIDTH{1'b0}};
            r_in_flight <= 2'd0;
        end else begin
            r_ret_valid <= w_issue;
            r_cap_valid <= r_ret_valid;
            r_cap_data  <= ramReadData;
            case ({w_issue, r_cap_valid})
                2'b10:   r_in_flight <= r_in_flight + 2'd1;
                2'b01:   r_in_flight <= r_in_flight - 2'd1;
                default: r_in_flight <= r_in_flight;
            endcase
        end
    end

    // busy covers the done cycle of a real burst but never a zero-length request.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_done <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_done <= w_done_next;
            r_busy <= (w_state_next != IDLE) || (r_state == DRAIN);
        end
    end

    ram_read_fifo #(
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk         (clk),
        .rstN        (rstN),
        .i_push      (r_cap_valid),
        .i_push_data (r_cap_data),
        .i_pop       (w_pop),
        .o_count     (w_fifo_count),
        .o_valid     (w_fifo_valid),
        .o_head      (w_fifo_head)
    );

    assign ramAddress = r_addr;
    assign outData    = w_fifo_head;
    assign outValid   = w_fifo_valid;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed and random-backpressure bench for ram_stream_reader with a word scoreboard.
module tb_ram_stream_reader;

    localparam int WIDTH   = 8;
    localparam int ENTRIES = 256;
    localparam int AW      = $clog2(ENTRIES);
    localparam int LW      = $clog2(ENTRIES + 1);

    logic             clk = 1'b0;
    logic             rstN;
    logic             s_start;
    logic [AW-1:0]    s_start_address;
    logic [LW-1:0]    s_length;
    logic [AW-1:0]    ramAddress;
    logic [WIDTH-1:0] ramReadData;
    logic [WIDTH-1:0] outData;
    logic             outValid;
    logic             outReady;
    logic             busy;
    logic             done;

    int checks   = 0;
    int errors   = 0;
    int pop_cnt  = 0;
    int done_cnt = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic             prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_data  = '0;

    always #5 clk = ~clk;

    // RAM model: RAM[i] = i with one-cycle registered read
    always @(posedge clk) ramReadData <= WIDTH'(ramAddress);

    ram_stream_reader #(.WIDTH(WIDTH), .ENTRIES(ENTRIES)) dut (
        .clk          (clk),
        .rstN         (rstN),
        .start        (s_start),
        .startAddress (s_start_address),
        .length       (s_length),
        .ramAddress   (ramAddress),
        .ramReadData  (ramReadData),
        .outData      (outData),
        .outValid     (outValid),
        .outReady     (outReady),
        .busy         (busy),
        .done         (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int addr, input int len);
        s_start_address = AW'(addr);
        s_length        = LW'(len);
        s_start         = 1'b1;
        tick();
        s_start = 1'b0;
        for (int i = 0; i < len; i++) exp_q.push_back(WIDTH'((addr + i) % ENTRIES));
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 3000) begin
            tick();
            n++;
        end
        check({tag, "_drained"}, exp_q.size(), 0);
        check({tag, "_busy_low"}, busy, 0);
    endtask

    // Scoreboard, stall-stability and done monitor
    always @(negedge clk) begin
        logic [WIDTH-1:0] e;
        if (rstN) begin
            if (outValid && outReady) begin
                pop_cnt++;
                check("sb_has_entry", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("sb_data", outData, e);
                end
            end
            if (prev_stall) check("stall_stable", outData, prev_data);
            prev_stall = outValid && !outReady;
            prev_data  = outData;
            if (done) done_cnt++;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        int d0;
        int p0;
        int n;
        rstN            = 1'b0;
        s_start         = 1'b0;
        s_start_address = '0;
        s_length        = '0;
        outReady        = 1'b0;
        repeat (2) tick();
        check("rst_valid", outValid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_addr", ramAddress, 0);
        rstN = 1'b1;
        tick();

        // Basic burst: latency, back-to-back words, done and busy timing
        outReady = 1'b1;
        d0 = done_cnt;
        do_start(10, 5);
        check("t1_busy_after_accept", busy, 1);
        check("t1_valid_e0", outValid, 0);
        tick();
        tick();
        check("t1_valid_e2", outValid, 0);
        tick();
        for (int k = 0; k < 5; k++) begin
            check("t1_valid_run", outValid, 1);
            check("t1_data_run", outData, 10 + k);
            tick();
        end
        check("t1_done", done, 1);
        check("t1_valid_end", outValid, 0);
        check("t1_busy_done_cycle", busy, 1);
        tick();
        check("t1_done_pulse", done, 0);
        check("t1_busy_low", busy, 0);
        check("t1_done_count", done_cnt - d0, 1);

        // Address wrap
        do_start(ENTRIES - 2, 4);
        check("t2_addr0", ramAddress, ENTRIES - 2);
        tick();
        check("t2_addr1", ramAddress, ENTRIES - 1);
        tick();
        check("t2_addr2", ramAddress, 0);
        tick();
        check("t2_addr3", ramAddress, 1);
        wait_drain("t2");

        // Stalled consumer: only FIFO_DEPTH reads may issue
        outReady = 1'b0;
        p0 = pop_cnt;
        do_start(40, 8);
        repeat (10) tick();
        check("t3_issues_while_stalled", ramAddress, 44);
        check("t3_valid_stalled", outValid, 1);
        outReady = 1'b1;
        wait_drain("t3");
        check("t3_word_count", pop_cnt - p0, 8);

        // Zero-length request
        d0 = done_cnt;
        do_start(5, 0);
        check("t4_busy", busy, 0);
        check("t4_done", done, 1);
        check("t4_valid", outValid, 0);
        tick();
        check("t4_done_off", done, 0);
        check("t4_busy_off", busy, 0);
        tick();
        check("t4_done_count", done_cnt - d0, 1);

        // Reset mid-burst, then a clean burst
        p0 = pop_cnt;
        do_start(100, 16);
        n = 0;
        while (pop_cnt < p0 + 3 && n < 100) begin
            tick();
            n++;
        end
        check("t5_three_words", (pop_cnt >= p0 + 3), 1);
        rstN = 1'b0;
        #1;
        check("t5_rst_valid", outValid, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_done", done, 0);
        check("t5_rst_addr", ramAddress, 0);
        exp_q.delete();
        tick();
        tick();
        rstN = 1'b1;
        d0 = done_cnt;
        repeat (3) tick();
        check("t5_no_done", done_cnt - d0, 0);
        check("t5_no_stale_valid", outValid, 0);
        do_start(30, 6);
        wait_drain("t5");

        // Full-depth burst with random backpressure and ignored starts
        d0 = done_cnt;
        p0 = pop_cnt;
        do_start(0, ENTRIES);
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 5000) begin
            outReady        = 1'($urandom_range(0, 1));
            s_start         = (exp_q.size() >= 2) && ($urandom_range(0, 7) == 0);
            s_start_address = AW'($urandom_range(0, ENTRIES - 1));
            s_length        = LW'($urandom_range(1, ENTRIES));
            tick();
            n++;
        end
        s_start  = 1'b0;
        outReady = 1'b1;
        check("t6_drained", exp_q.size(), 0);
        check("t6_word_count", pop_cnt - p0, ENTRIES);
        check("t6_done_count", done_cnt - d0, 1);
        check("t6_busy_low", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
